// File: rtl/alien_march_sequencer.sv
// -----------------------------------------------------------------------------
// alien_march_sequencer
//
// Paces the alien formation: counts video frames, and once per "period" frames
// issues a one-cycle motion command (LEFT / RIGHT / DOWN) to the formation
// datapath. At a screen edge it emits DOWN and reverses direction. The period
// shrinks as aliens die. On victory or defeat the sequencer freezes until reset.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   enable      1 = march runs, 0 = pause (counters hold)
//   frame_tick  one-cycle pulse per video frame
//   can_left    formation may step left
//   can_right   formation may step right
//   alive       per-alien alive mask
//   victory     all aliens dead
//   defeat      formation reached the player zone
//   motion      0 none, 1 LEFT, 2 RIGHT, 3 DOWN (one-cycle pulse)
//   dir_right   current horizontal direction, 1 = right
//   step_pulse  high with any nonzero motion
//   halted      frozen on victory/defeat
//   period      current frames-per-step
// -----------------------------------------------------------------------------
module alien_march_sequencer #(
  parameter int NB_ALIENS     = 4,
  parameter int BASE_PERIOD   = 30,
  parameter int MIN_PERIOD    = 2,
  parameter int SPEEDUP       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int PW            = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic                 can_left,
  input  logic                 can_right,
  input  logic [NB_ALIENS-1:0] alive,
  input  logic                 victory,
  input  logic                 defeat,
  output logic [1:0]           motion,
  output logic                 dir_right,
  output logic                 step_pulse,
  output logic                 halted,
  output logic [PW-1:0]        period
);

  // Width of the killed counter (must hold 0..NB_ALIENS).
  localparam int KW  = $clog2(NB_ALIENS + 1);
  // Signed width for the period subtraction so underflow is visible as negative.
  localparam int SW  = PW + $clog2(NB_ALIENS) + 1;
  localparam int SCW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [1:0]     MOT_NONE  = 2'd0;
  localparam logic [1:0]     MOT_LEFT  = 2'd1;
  localparam logic [1:0]     MOT_RIGHT = 2'd2;
  localparam logic [1:0]     MOT_DOWN  = 2'd3;

  localparam logic [PW-1:0]  BASE_P      = PW'(BASE_PERIOD);
  localparam logic [PW-1:0]  MIN_P       = PW'(MIN_PERIOD);
  localparam logic [PW-1:0]  FRAME_MAX   = {PW{1'b1}};
  localparam logic [SCW-1:0] SETTLE_INIT = SCW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t         state;
  logic [KW-1:0]  killedR;
  logic [PW-1:0]  frameCnt;
  logic [SCW-1:0] settleCnt;
  // A period that expired while settling; fires on the first WAIT cycle.
  logic           stepPending;

  logic signed [SW-1:0] periodCalcS;
  logic [PW-1:0]        periodNextS;
  logic [PW:0]          frameIncS;
  logic                 expireS;
  logic [PW-1:0]        frameSatS;

  // Number of set bits in the alive mask.
  function automatic logic [KW-1:0] countAlive(input logic [NB_ALIENS-1:0] mask);
    logic [KW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NB_ALIENS; i++) begin
      acc = acc + KW'(mask[i]);
    end
    return acc;
  endfunction

  // Next period: base minus speedup per kill, clamped to the floor.
  always_comb begin
    periodCalcS = $signed(SW'(BASE_PERIOD)) - ($signed(SW'(killedR)) * $signed(SW'(SPEEDUP)));
    if (periodCalcS < $signed(SW'(MIN_PERIOD))) begin
      periodNextS = MIN_P;
    end else begin
      periodNextS = periodCalcS[PW-1:0];
    end
  end

  // Frame counter helpers: expiry test on frame_cnt+1 and saturating increment.
  always_comb begin
    frameIncS = {1'b0, frameCnt} + {{PW{1'b0}}, 1'b1};
    expireS   = (frameIncS >= {1'b0, period});
    if (frameCnt == FRAME_MAX) begin
      frameSatS = frameCnt;
    end else begin
      frameSatS = frameCnt + PW'(1);
    end
  end

  // Period pipeline: killed count then clamped period, one register each.
  always_ff @(posedge clk) begin
    if (reset) begin
      killedR <= '0;
      period  <= BASE_P;
    end else begin
      killedR <= KW'(NB_ALIENS) - countAlive(alive);
      period  <= periodNextS;
    end
  end

  // March FSM with registered motion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_WAIT;
      frameCnt    <= '0;
      settleCnt   <= '0;
      stepPending <= 1'b0;
      motion      <= MOT_NONE;
      step_pulse  <= 1'b0;
      dir_right   <= 1'b1;
      halted      <= 1'b0;
    end else begin
      motion     <= MOT_NONE;
      step_pulse <= 1'b0;
      // End of game overrides any step decided in the same cycle.
      if (victory || defeat) begin
        state       <= ST_HALT;
        halted      <= 1'b1;
        stepPending <= 1'b0;
      end else begin
        case (state)
          ST_WAIT: begin
            if (enable && (stepPending || (frame_tick && expireS))) begin
              frameCnt    <= '0;
              stepPending <= 1'b0;
              state       <= ST_STEP;
              step_pulse  <= 1'b1;
              if (dir_right) begin
                if (can_right) begin
                  motion <= MOT_RIGHT;
                end else begin
                  motion    <= MOT_DOWN;
                  dir_right <= 1'b0;
                end
              end else begin
                if (can_left) begin
                  motion <= MOT_LEFT;
                end else begin
                  motion    <= MOT_DOWN;
                  dir_right <= 1'b1;
                end
              end
            end else if (enable && frame_tick) begin
              frameCnt <= frameSatS;
            end else begin
              frameCnt <= frameCnt;
            end
          end
          ST_STEP, ST_SETTLE: begin
            // Frames keep counting while the datapath settles; an expiry is
            // remembered rather than acted on, so one step per window at most.
            if (enable && frame_tick) begin
              if (!stepPending && expireS) begin
                stepPending <= 1'b1;
                frameCnt    <= '0;
              end else begin
                frameCnt <= frameSatS;
              end
            end else begin
              frameCnt <= frameCnt;
            end
            if (state == ST_STEP) begin
              state     <= ST_SETTLE;
              settleCnt <= SETTLE_INIT;
            end else if (enable) begin
              if (settleCnt <= SCW'(1)) begin
                settleCnt <= '0;
                state     <= ST_WAIT;
              end else begin
                settleCnt <= settleCnt - SCW'(1);
              end
            end else begin
              settleCnt <= settleCnt;
            end
          end
          ST_HALT: begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end
          default: begin
            state <= ST_WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alien_march_sequencer.sv
module tb_alien_march_sequencer;

  localparam logic [1:0] M_NONE  = 2'd0;
  localparam logic [1:0] M_LEFT  = 2'd1;
  localparam logic [1:0] M_RIGHT = 2'd2;
  localparam logic [1:0] M_DOWN  = 2'd3;

  logic       clk = 1'b0;
  logic       reset, enable, frame_tick, can_left, can_right, victory, defeat;
  logic [3:0] alive;

  logic [1:0] motion, motion2;
  logic       dir_right, dir_right2, step_pulse, step_pulse2, halted, halted2;
  logic [7:0] period, period2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lastPulse = -100;
  logic [1:0] expQ[$];

  alien_march_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .can_left(can_left), .can_right(can_right), .alive(alive),
    .victory(victory), .defeat(defeat), .motion(motion), .dir_right(dir_right),
    .step_pulse(step_pulse), .halted(halted), .period(period)
  );

  // Second instance with a steep speedup to exercise the clamp.
  alien_march_sequencer #(.SPEEDUP(10)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .can_left(can_left), .can_right(can_right), .alive(alive),
    .victory(victory), .defeat(defeat), .motion(motion2), .dir_right(dir_right2),
    .step_pulse(step_pulse2), .halted(halted2), .period(period2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous monitor: step_pulse tracks motion, pulses are well separated.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      lastPulse = -100;
    end else begin
      check("step_pulse_coincident", 32'(step_pulse), 32'(motion != 2'd0));
      if (motion != 2'd0) begin
        check("pulse_spacing", 32'(cyc - lastPulse >= 3), 32'd1);
        lastPulse = cyc;
      end
    end
  end

  // Issue n frame ticks 10 clk apart; only the last may produce expLast.
  task automatic runFrames(input int n, input logic [1:0] expLast);
    for (int i = 0; i < n; i++) begin
      bit quiet;
      expQ.push_back((i == n - 1) ? expLast : M_NONE);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check("frame_motion", 32'(motion), 32'(expQ.pop_front()));
      quiet = 1'b1;
      repeat (9) begin
        @(negedge clk);
        if (motion !== 2'd0) quiet = 1'b0;
      end
      check("idle_quiet", 32'(quiet), 32'd1);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] aliveMask;
    logic [7:0] p4;
    logic [7:0] p10;
  } pvec_t;

  pvec_t pv[6];
  logic [7:0] prevP, prevP2;

  initial begin
    pv[0] = '{4'hF, 8'd30, 8'd30};
    pv[1] = '{4'h7, 8'd26, 8'd20};
    pv[2] = '{4'h3, 8'd22, 8'd10};
    pv[3] = '{4'h1, 8'd18, 8'd2};
    pv[4] = '{4'h0, 8'd14, 8'd2};
    pv[5] = '{4'hE, 8'd26, 8'd20};

    reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; can_left = 1'b1;
    can_right = 1'b1; alive = 4'hF; victory = 1'b0; defeat = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_motion", 32'(motion), 32'd0);
    check("rst_step_pulse", 32'(step_pulse), 32'd0);
    check("rst_dir_right", 32'(dir_right), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_period", 32'(period), 32'd30);
    reset = 1'b0;
    @(negedge clk);

    // Period pipeline table (march paused).
    prevP = 8'd30; prevP2 = 8'd30;
    for (int i = 0; i < 6; i++) begin
      alive = pv[i].aliveMask;
      @(negedge clk);
      check("period_latency", 32'(period), 32'(prevP));
      @(negedge clk);
      check("period_speedup4", 32'(period), 32'(pv[i].p4));
      check("period_speedup10", 32'(period2), 32'(pv[i].p10));
      prevP = pv[i].p4; prevP2 = pv[i].p10;
    end
    alive = 4'hF;
    repeat (2) @(negedge clk);
    doReset();

    // Basic march, edge drop and reversal.
    enable = 1'b1;
    runFrames(30, M_RIGHT);
    check("dir_after_right", 32'(dir_right), 32'd1);
    runFrames(30, M_RIGHT);
    can_right = 1'b0;
    runFrames(30, M_DOWN);
    check("dir_after_right_edge", 32'(dir_right), 32'd0);
    runFrames(30, M_LEFT);
    check("dir_after_left", 32'(dir_right), 32'd0);
    can_left = 1'b0;
    runFrames(30, M_DOWN);
    check("dir_after_left_edge", 32'(dir_right), 32'd1);
    can_left = 1'b1; can_right = 1'b1;

    // Pause mid-count: 12 frames, 50 paused, remaining 18.
    runFrames(12, M_NONE);
    enable = 1'b0;
    runFrames(50, M_NONE);
    enable = 1'b1;
    runFrames(18, M_RIGHT);

    // Faster march with two aliens killed.
    alive = 4'b0011;
    repeat (2) @(negedge clk);
    check("period_two_killed", 32'(period), 32'd22);
    runFrames(22, M_RIGHT);
    alive = 4'hF;
    repeat (2) @(negedge clk);
    check("period_restored", 32'(period), 32'd30);

    // Reset while settling after a DOWN step.
    can_right = 1'b0;
    runFrames(29, M_NONE);
    expQ.push_back(M_DOWN);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("settle_step_motion", 32'(motion), 32'(expQ.pop_front()));
    check("settle_step_dir", 32'(dir_right), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("settle_rst_motion", 32'(motion), 32'd0);
    check("settle_rst_dir", 32'(dir_right), 32'd1);
    reset = 1'b0;
    can_right = 1'b1;
    runFrames(30, M_RIGHT);

    // Defeat coincident with period expiry: halt wins.
    runFrames(29, M_NONE);
    expQ.push_back(M_NONE);
    frame_tick = 1'b1;
    defeat = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    defeat = 1'b0;
    check("defeat_motion", 32'(motion), 32'(expQ.pop_front()));
    check("defeat_halted", 32'(halted), 32'd1);
    runFrames(40, M_NONE);
    check("halt_sticky", 32'(halted), 32'd1);
    doReset();
    check("halt_cleared", 32'(halted), 32'd0);

    // Victory halts from WAIT.
    runFrames(3, M_NONE);
    victory = 1'b1;
    @(negedge clk);
    victory = 1'b0;
    check("victory_halted", 32'(halted), 32'd1);
    runFrames(30, M_NONE);
    doReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
